calc_entry: RTL and testbench

Calculator entry and arithmetic engine. It sits directly downstream of the PS/2 scan stage and consumes the scanner's key-press strobe and ASCII-style key code. It assembles decimal keystrokes into two unsigned operands and an operator. On '=' it computes the result, single-cycle for + − × and a multi-cycle sequential divider for ÷, and presents it to the display stage.

---
 rtl/calc_pkg.sv | 35 +++
 rtl/calc_div.sv | 55 +++++
 rtl/calc_entry.sv | 182 ++++++++++++++++++
 tb/tb_calc_entry.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator entry engine.
// Key codes match the PS/2 scan stage lookup table.
package calc_pkg;

  localparam int DEF_MAX_DIGITS = 4;
  localparam int DEF_OPW        = 14;
  localparam int DEF_RESW       = 28;

  typedef enum logic [1:0] {
    ST_A_ENTRY,
    ST_B_ENTRY,
    ST_CALC,
    ST_DONE
  } state_e;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  localparam logic [7:0] KEY_0    = 8'h30;
  localparam logic [7:0] KEY_9    = 8'h39;
  localparam logic [7:0] KEY_ADD  = 8'h61;
  localparam logic [7:0] KEY_SUB  = 8'h62;
  localparam logic [7:0] KEY_MUL  = 8'h63;
  localparam logic [7:0] KEY_DIV  = 8'h64;
  localparam logic [7:0] KEY_EQ   = 8'h65;
  localparam logic [7:0] KEY_NONE = 8'hFE;

  // 0x61..0x64 low bits are 01,10,11,00; minus one gives add..div
  function automatic logic [1:0] key_to_op(input logic [1:0] lo);
    return lo - 2'd1;
  endfunction

endpackage

// File: rtl/calc_div.sv
// OPW-bit unsigned restoring divider, one quotient bit per cycle.
// quotient_o/remainder_o are the final values in the cycle done_o is high.
module calc_div
  import calc_pkg::*;
#(
  parameter int OPW = DEF_OPW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [OPW-1:0] dividend_i,
  input  logic [OPW-1:0] divisor_i,
  output logic [OPW-1:0] quotient_o,
  output logic [OPW-1:0] remainder_o,
  output logic           done_o,
  output logic           busy_o
);

  localparam int CW = $clog2(OPW + 1);

  logic [OPW-1:0] rem_q, quo_q, dvs_q;
  logic [OPW-1:0] rem_d, quo_d, shl;
  logic [CW-1:0]  cnt_q;
  logic           ge;

  // rem_q MSB is the bit shifted out of shl; if set, shl+2^OPW >= divisor
  assign shl   = {rem_q[OPW-2:0], quo_q[OPW-1]};
  assign ge    = rem_q[OPW-1] | (shl >= dvs_q);
  assign rem_d = ge ? shl - dvs_q : shl;
  assign quo_d = {quo_q[OPW-2:0], ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      dvs_q <= divisor_i;
      cnt_q <= CW'(OPW);
    end else if (cnt_q != '0) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign quotient_o  = quo_d;
  assign remainder_o = rem_d;
  assign done_o      = (cnt_q == CW'(1));
  assign busy_o      = (cnt_q != '0);

endmodule

// File: rtl/calc_entry.sv
// Calculator entry FSM: assembles decimal operands from scanner keys
// and evaluates + - x in one cycle, / through calc_div.
module calc_entry
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = DEF_MAX_DIGITS,
  parameter int OPW        = DEF_OPW,
  parameter int RESW       = DEF_RESW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            key_valid,
  input  logic [7:0]      key_code,
  output logic [OPW-1:0]  entry_val,
  output logic [1:0]      op_code,
  output logic [RESW-1:0] result,
  output logic [OPW-1:0]  remainder,
  output logic            result_valid,
  output logic            err,
  output logic            busy
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  state_e          state_q, state_d;
  logic            kv_q;
  logic [OPW-1:0]  a_q, a_d, b_q, b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic [RESW-1:0] res_q, res_d;
  logic [OPW-1:0]  rem_q, rem_d;
  logic            rv_q, rv_d;
  logic            err_q, err_d;

  logic            is_dig, is_op, is_eq, can_take;
  logic [OPW-1:0]  cur, acc;
  logic [RESW-1:0] a_x, b_x, arith;
  logic            div_start, div_done, div_busy;
  logic [OPW-1:0]  div_quo, div_rem;

  // key_code lags the scanner strobe by one cycle
  assign is_dig = kv_q && key_code >= KEY_0 && key_code <= KEY_9;
  assign is_op  = kv_q && key_code >= KEY_ADD && key_code <= KEY_DIV;
  assign is_eq  = kv_q && key_code == KEY_EQ;

  assign can_take = cnt_q < CW'(MAX_DIGITS);
  assign cur = (state_q == ST_A_ENTRY) ? a_q : b_q;
  assign acc = (cur << 3) + (cur << 1) + OPW'(key_code[3:0]);

  assign a_x = RESW'(a_q);
  assign b_x = RESW'(b_q);

  always_comb begin
    arith = a_x + b_x;
    if (op_q == OP_SUB)      arith = a_x - b_x;
    else if (op_q == OP_MUL) arith = a_x * b_x;
  end

  assign div_start = state_q == ST_B_ENTRY && is_eq &&
                     op_q == OP_DIV && b_q != '0;

  calc_div #(.OPW(OPW)) u_div (
    .clk         (clk),
    .rst         (rst),
    .start_i     (div_start),
    .dividend_i  (a_q),
    .divisor_i   (b_q),
    .quotient_o  (div_quo),
    .remainder_o (div_rem),
    .done_o      (div_done),
    .busy_o      (div_busy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_A_ENTRY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_A_ENTRY: if (is_op) state_d = ST_B_ENTRY;
      ST_B_ENTRY: if (is_eq) state_d = ST_CALC;
      ST_CALC:    if (div_done || !div_busy) state_d = ST_DONE;
      ST_DONE:    if (is_dig) state_d = ST_A_ENTRY;
      default:    state_d = ST_A_ENTRY;
    endcase
  end

  always_comb begin
    busy      = (state_q == ST_CALC);
    entry_val = (state_q == ST_A_ENTRY) ? a_q : b_q;
  end

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    op_d  = op_q;
    res_d = res_q;
    rem_d = rem_q;
    err_d = err_q;
    rv_d  = 1'b0;
    unique case (state_q)
      ST_A_ENTRY: begin
        if (is_dig && can_take) begin
          a_d   = acc;
          cnt_d = cnt_q + CW'(1);
        end
        if (is_op) begin
          op_d  = key_to_op(key_code[1:0]);
          cnt_d = '0;
        end
      end
      ST_B_ENTRY: begin
        if (is_dig && can_take) begin
          b_d   = acc;
          cnt_d = cnt_q + CW'(1);
        end
        if (is_op && cnt_q == '0) op_d = key_to_op(key_code[1:0]);
      end
      ST_CALC: begin
        if (op_q != OP_DIV) begin
          res_d = arith;
          rem_d = '0;
          err_d = 1'b0;
          rv_d  = 1'b1;
        end else if (div_done) begin
          res_d = RESW'(div_quo);
          rem_d = div_rem;
          err_d = 1'b0;
          rv_d  = 1'b1;
        end else if (!div_busy) begin
          res_d = '0;
          rem_d = '0;
          err_d = 1'b1;
          rv_d  = 1'b1;
        end
      end
      ST_DONE: begin
        if (is_dig) begin
          a_d   = OPW'(key_code[3:0]);
          b_d   = '0;
          cnt_d = CW'(1);
          err_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kv_q  <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      op_q  <= OP_ADD;
      res_q <= '0;
      rem_q <= '0;
      rv_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      kv_q  <= key_valid && !busy;
      a_q   <= a_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
      op_q  <= op_d;
      res_q <= res_d;
      rem_q <= rem_d;
      rv_q  <= rv_d;
      err_q <= err_d;
    end
  end

  assign op_code      = op_q;
  assign result       = res_q;
  assign remainder    = rem_q;
  assign result_valid = rv_q;
  assign err          = err_q;

endmodule

// File: tb/tb_calc_entry.sv
// Directed and random key sequences for calc_entry, checked against
// plain integer arithmetic on the typed operands.
module tb_calc_entry;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_valid = 1'b0;
  logic [7:0]  key_code = 8'hFE;
  logic [13:0] entry_val;
  logic [1:0]  op_code;
  logic [27:0] result;
  logic [13:0] remainder;
  logic        result_valid, err, busy;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  calc_entry dut (
    .clk          (clk),
    .rst          (rst),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .entry_val    (entry_val),
    .op_code      (op_code),
    .result       (result),
    .remainder    (remainder),
    .result_valid (result_valid),
    .err          (err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " entry_val"}, entry_val, 0);
    chk({tag, " op_code"}, op_code, 0);
    chk({tag, " result"}, result, 0);
    chk({tag, " remainder"}, remainder, 0);
    chk({tag, " result_valid"}, result_valid, 0);
    chk({tag, " err"}, err, 0);
    chk({tag, " busy"}, busy, 0);
  endtask

  // strobe in cycle S-1, code in cycle S; returns early in S+1
  task automatic press(input logic [7:0] c);
    @(posedge clk); #1;
    key_valid = 1'b1;
    key_code  = 8'hFE;
    @(posedge clk); #1;
    key_valid = 1'b0;
    key_code  = c;
    @(posedge clk); #1;
    key_code  = 8'hFE;
  endtask

  function automatic logic [7:0] kc(input byte ch);
    case (ch)
      8'h2B:   return 8'h61;
      8'h2D:   return 8'h62;
      8'h2A:   return 8'h63;
      8'h2F:   return 8'h64;
      8'h3D:   return 8'h65;
      default: return ch;
    endcase
  endfunction

  task automatic enter(input string s);
    for (int i = 0; i < s.len(); i++) press(kc(s[i]));
  endtask

  // called in S+1 of the '=' key; lat counts cycles from S
  task automatic wait_result(input string tag, input int exp_lat,
                             input logic [31:0] er,
                             input logic [31:0] erem,
                             input logic ee);
    int lat, bc;
    lat = 0;
    bc  = 0;
    @(negedge clk);
    if (busy) bc++;
    for (int k = 2; k <= 40; k++) begin
      @(negedge clk);
      if (result_valid) begin
        lat = k;
        break;
      end
      if (busy) bc++;
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " busy cycles"}, bc, exp_lat - 1);
    chk({tag, " result"}, result, er);
    chk({tag, " remainder"}, remainder, erem);
    chk({tag, " err"}, err, ee);
    chk({tag, " busy at result"}, busy, 0);
    @(negedge clk);
    chk({tag, " valid one cycle"}, result_valid, 0);
  endtask

  initial begin
    int rv_seen;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    @(posedge clk); #1 rst = 1'b0;

    enter("12");
    press(8'h7A);
    press(8'hFE);
    @(negedge clk);
    chk("A after junk keys", entry_val, 12);
    enter("+34=");
    wait_result("add", 2, 46, 0, 0);
    chk("add op_code", op_code, 0);

    enter("5-9=");
    wait_result("sub", 2, 32'h0FFFFFFC, 0, 0);

    enter("99999");
    @(negedge clk);
    chk("A digit limit", entry_val, 9999);
    enter("*9999=");
    wait_result("mul", 2, 99980001, 0, 0);

    enter("100/7=");
    fork
      begin
        repeat (3) @(posedge clk);
        press(8'h35);
      end
      wait_result("div", 15, 14, 2, 0);
    join
    chk("div dropped key", entry_val, 7);
    chk("div op_code", op_code, 3);

    enter("8/0=");
    wait_result("div0", 2, 0, 0, 1);
    enter("3");
    @(negedge clk);
    chk("div0 err cleared", err, 0);
    chk("div0 new A", entry_val, 3);
    chk("div0 not busy", busy, 0);
    enter("+1=");
    wait_result("after div0", 2, 4, 0, 0);

    enter("6+-2=");
    wait_result("op replace", 2, 4, 0, 0);
    enter("6+2-");
    @(negedge clk);
    chk("op kept after B digit", op_code, 0);
    enter("=");
    wait_result("op kept", 2, 8, 0, 0);

    enter("100/7=");
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk_reset("mid-div reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rv_seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (result_valid) rv_seen = 1;
    end
    chk("no result after reset", rv_seen, 0);

    for (int it = 0; it < 20; it++) begin
      int na, nb, op, a, b, d, el;
      logic [31:0] er, erem;
      logic ee;
      na = $urandom_range(5, 1);
      nb = $urandom_range(5, 0);
      op = $urandom_range(3, 0);
      a = 0;
      for (int i = 0; i < na; i++) begin
        d = $urandom_range(9, 0);
        press(8'(48 + d));
        if (i < 4) a = a * 10 + d;
      end
      @(negedge clk);
      chk("rnd entry A", entry_val, a);
      press(8'(97 + op));
      b = 0;
      for (int i = 0; i < nb; i++) begin
        d = $urandom_range(9, 0);
        press(8'(48 + d));
        if (i < 4) b = b * 10 + d;
      end
      press(8'h65);
      ee = 1'b0;
      erem = 0;
      el = 2;
      case (op)
        0: er = a + b;
        1: er = (a - b) & 32'h0FFFFFFF;
        2: er = a * b;
        default: begin
          if (b == 0) begin
            ee = 1'b1;
            er = 0;
          end else begin
            er = a / b;
            erem = a % b;
            el = 15;
          end
        end
      endcase
      wait_result("rnd", el, er, erem, ee);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
